// File: rtl/scoreboard_ctrl_if.sv
// Button/score bundle between the synchronisers, the score controller and the display path.
// Latency: none, wires only.
// Backpressure: none; button inputs are levels and outputs are plain registered values.
// Ports:
//   a_up_i/a_down_i/b_up_i/b_down_i  synchronised button levels
//   clear_i                          synchronous score clear
//   score_a_o/score_b_o              team scores
//   upd_valid_o/upd_team_o           change pulse and team of last change
//   busy_a_o/busy_b_o                per-team busy (pending or hold-off)
//   score_a_bcd_o/score_b_bcd_o      BCD scores, only with SCOREBOARD_BCD_EN defined
interface scoreboard_ctrl_if #(
  parameter int BW = 7
);
  logic          a_up_i;
  logic          a_down_i;
  logic          b_up_i;
  logic          b_down_i;
  logic          clear_i;
  logic [BW-1:0] score_a_o;
  logic [BW-1:0] score_b_o;
  logic          upd_valid_o;
  logic          upd_team_o;
  logic          busy_a_o;
  logic          busy_b_o;
`ifdef SCOREBOARD_BCD_EN
  logic [7:0]    score_a_bcd_o;
  logic [7:0]    score_b_bcd_o;

  modport master (
    output a_up_i, a_down_i, b_up_i, b_down_i, clear_i,
    input  score_a_o, score_b_o, upd_valid_o, upd_team_o, busy_a_o, busy_b_o,
    input  score_a_bcd_o, score_b_bcd_o
  );
  modport slave (
    input  a_up_i, a_down_i, b_up_i, b_down_i, clear_i,
    output score_a_o, score_b_o, upd_valid_o, upd_team_o, busy_a_o, busy_b_o,
    output score_a_bcd_o, score_b_bcd_o
  );
`else
  modport master (
    output a_up_i, a_down_i, b_up_i, b_down_i, clear_i,
    input  score_a_o, score_b_o, upd_valid_o, upd_team_o, busy_a_o, busy_b_o
  );
  modport slave (
    input  a_up_i, a_down_i, b_up_i, b_down_i, clear_i,
    output score_a_o, score_b_o, upd_valid_o, upd_team_o, busy_a_o, busy_b_o
  );
`endif
endinterface

// File: rtl/scoreboard_ctrl.sv
// Two-team score controller: button edge detect, round-robin shared update, saturation, hold-off.
// Latency: edge sampled at k -> score written at k+1 (k+2 if it loses arbitration).
// Backpressure: none; edges arriving while a team is pending or in hold-off are dropped.
// Ports: clk_i (posedge), rst_i (sync, active-high, beats clear), sb (scoreboard_ctrl_if.slave).
// Optional: define SCOREBOARD_BCD_EN to drive sb.score_a_bcd_o/score_b_bcd_o (needs MAX_VAL <= 99).
module scoreboard_ctrl #(
  parameter int BW      = 7,
  parameter int MAX_VAL = 99,
  parameter int HOLDOFF = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  scoreboard_ctrl_if.slave sb
);
  // hold-off counter is loaded with HOLDOFF-1 and counts down to zero
  localparam int            CW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);
  localparam logic [BW-1:0] MAX_V     = BW'(MAX_VAL);

  generate
    if (MAX_VAL >= (1 << BW) || MAX_VAL < 0 || HOLDOFF < 1) begin : g_bad_param
      $error("scoreboard_ctrl: need 0 <= MAX_VAL < 2**BW and HOLDOFF >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, HOLD = 2'd2} state_t;

  // index 0 = team A, index 1 = team B
  state_t        st        [2];
  logic [CW-1:0] cnt       [2];
  logic [BW-1:0] score     [2];
  logic [BW-1:0] nxt_score [2];
  logic [1:0]    dir_up;
  logic [1:0]    busy_q;
  logic [1:0]    up_q, dn_q;
  logic [1:0]    up_lvl, dn_lvl;
  logic [1:0]    rise_up, rise_dn;
  logic [1:0]    pend, gnt, chg;
  logic          rr_ptr;
  logic          upd_valid_q;
  logic          upd_team_q;

  assign up_lvl  = {sb.b_up_i, sb.a_up_i};
  assign dn_lvl  = {sb.b_down_i, sb.a_down_i};
  assign rise_up = up_lvl & ~up_q;
  assign rise_dn = dn_lvl & ~dn_q;
  assign pend    = {st[1] == PEND, st[0] == PEND};

  // single grant per cycle; the pointer only breaks ties
  always_comb begin
    gnt = pend;
    if (&pend) begin
      gnt         = 2'b00;
      gnt[rr_ptr] = 1'b1;
    end
  end

  // saturating step; chg=0 means the request is consumed without a visible change
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nxt_score[i] = score[i];
      chg[i]       = 1'b0;
      if (dir_up[i]) begin
        if (score[i] != MAX_V) begin
          nxt_score[i] = score[i] + BW'(1);
          chg[i]       = 1'b1;
        end
      end else if (score[i] != '0) begin
        nxt_score[i] = score[i] - BW'(1);
        chg[i]       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up_q        <= 2'b00;
      dn_q        <= 2'b00;
      rr_ptr      <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_team_q  <= 1'b0;
      dir_up      <= 2'b00;
      busy_q      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        st[i]    <= IDLE;
        cnt[i]   <= '0;
        score[i] <= '0;
      end
    end else begin
      // edge history keeps running through clear so a held button does not re-fire
      up_q <= up_lvl;
      dn_q <= dn_lvl;
      if (sb.clear_i) begin
        rr_ptr      <= 1'b0;
        upd_valid_q <= 1'b0;
        busy_q      <= 2'b00;
        for (int i = 0; i < 2; i++) begin
          st[i]    <= IDLE;
          cnt[i]   <= '0;
          score[i] <= '0;
        end
      end else begin
        upd_valid_q <= 1'b0;
        if (&pend) rr_ptr <= ~rr_ptr;
        for (int i = 0; i < 2; i++) begin
          case (st[i])
            IDLE: begin
              // simultaneous up and down cancel each other
              if (rise_up[i] ^ rise_dn[i]) begin
                st[i]     <= PEND;
                dir_up[i] <= rise_up[i];
                busy_q[i] <= 1'b1;
              end
            end
            PEND: begin
              if (gnt[i]) begin
                score[i] <= nxt_score[i];
                st[i]    <= HOLD;
                cnt[i]   <= HOLD_LOAD;
                if (chg[i]) begin
                  upd_valid_q <= 1'b1;
                  upd_team_q  <= (i == 1);
                end
              end
            end
            HOLD: begin
              if (cnt[i] == '0) begin
                st[i]     <= IDLE;
                busy_q[i] <= 1'b0;
              end else begin
                cnt[i] <= cnt[i] - CW'(1);
              end
            end
            default: begin
              st[i]     <= IDLE;
              busy_q[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign sb.score_a_o   = score[0];
  assign sb.score_b_o   = score[1];
  assign sb.upd_valid_o = upd_valid_q;
  assign sb.upd_team_o  = upd_team_q;
  assign sb.busy_a_o    = busy_q[0];
  assign sb.busy_b_o    = busy_q[1];

`ifdef SCOREBOARD_BCD_EN
  generate
    if (MAX_VAL > 99) begin : g_bad_bcd
      $error("scoreboard_ctrl: BCD output needs MAX_VAL <= 99");
    end
  endgenerate

  function automatic logic [7:0] to_bcd(input logic [BW-1:0] v);
    int tens;
    int units;
    tens  = int'(v) / 10;
    units = int'(v) % 10;
    return {4'(tens), 4'(units)};
  endfunction

  assign sb.score_a_bcd_o = to_bcd(score[0]);
  assign sb.score_b_bcd_o = to_bcd(score[1]);
`endif
endmodule

// File: tb/tb_scoreboard_ctrl.sv
module tb_scoreboard_ctrl;
  localparam int BW   = 7;
  localparam int MAXV = 99;
  localparam int HO   = 4;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  scoreboard_ctrl_if #(.BW(BW)) sb ();

  scoreboard_ctrl #(.BW(BW), .MAX_VAL(MAXV), .HOLDOFF(HO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pending flag, direction, remaining cool-down cycles per team
  int m_score [2];
  bit m_pend  [2];
  int m_dir   [2];
  int m_cool  [2];
  int m_ptr;
  bit m_uv;
  bit m_ut;
  bit m_pu    [2];
  bit m_pd    [2];

  task automatic model_edge();
    bit u [2];
    bit d [2];
    bit was_idle [2];
    int g;
    int nv;
    u[0] = sb.a_up_i; u[1] = sb.b_up_i;
    d[0] = sb.a_down_i; d[1] = sb.b_down_i;
    if (rst) begin
      for (int t = 0; t < 2; t++) begin
        m_score[t] = 0; m_pend[t] = 0; m_dir[t] = 1; m_cool[t] = 0; m_pu[t] = 0; m_pd[t] = 0;
      end
      m_ptr = 0; m_uv = 0; m_ut = 0;
      return;
    end
    if (sb.clear_i) begin
      for (int t = 0; t < 2; t++) begin
        m_score[t] = 0; m_pend[t] = 0; m_cool[t] = 0;
      end
      m_ptr = 0; m_uv = 0;
    end else begin
      g = -1;
      if (m_pend[0] && m_pend[1]) begin g = m_ptr; m_ptr = 1 - m_ptr; end
      else if (m_pend[0]) g = 0;
      else if (m_pend[1]) g = 1;
      for (int t = 0; t < 2; t++) begin
        was_idle[t] = !m_pend[t] && (m_cool[t] == 0);
        if (m_cool[t] > 0) m_cool[t]--;
      end
      m_uv = 0;
      if (g >= 0) begin
        nv = m_score[g] + m_dir[g];
        if (nv >= 0 && nv <= MAXV) begin
          m_score[g] = nv; m_uv = 1; m_ut = (g == 1);
        end
        m_pend[g] = 0;
        m_cool[g] = HO;
      end
      for (int t = 0; t < 2; t++) begin
        if (was_idle[t] && ((u[t] && !m_pu[t]) != (d[t] && !m_pd[t]))) begin
          m_pend[t] = 1;
          m_dir[t]  = (u[t] && !m_pu[t]) ? 1 : -1;
        end
      end
    end
    for (int t = 0; t < 2; t++) begin m_pu[t] = u[t]; m_pd[t] = d[t]; end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_btn(input bit au, input bit ad, input bit bu, input bit bd);
    sb.a_up_i = au; sb.a_down_i = ad; sb.b_up_i = bu; sb.b_down_i = bd;
  endtask

  task automatic do_reset();
    rst = 1'b1; sb.clear_i = 1'b0;
    set_btn(0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
  endtask

  // one button press, then wait until the team is free again
  task automatic pulse(input int team, input bit up);
    if (team == 0) set_btn(up, !up, 0, 0); else set_btn(0, 0, up, !up);
    step();
    set_btn(0, 0, 0, 0);
    step();
    repeat (HO) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; sb.clear_i = 1'b0;
    set_btn(1, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    n_vec++; if (sb.score_a_o !== 7'd0) begin n_err++; $display("FAIL rst_score_a: got %0d expected 0", sb.score_a_o); end
    n_vec++; if (sb.score_b_o !== 7'd0) begin n_err++; $display("FAIL rst_score_b: got %0d expected 0", sb.score_b_o); end
    n_vec++; if (sb.upd_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_upd_valid: got %b expected 0", sb.upd_valid_o); end
    n_vec++; if (sb.upd_team_o !== 1'b0) begin n_err++; $display("FAIL rst_upd_team: got %b expected 0", sb.upd_team_o); end
    n_vec++; if ({sb.busy_a_o, sb.busy_b_o} !== 2'b00) begin n_err++; $display("FAIL rst_busy: got %b%b expected 00", sb.busy_a_o, sb.busy_b_o); end
    // button held through reset counts as a fresh edge
    step();
    n_vec++; if (sb.busy_a_o !== 1'b1) begin n_err++; $display("FAIL rst_held_edge_busy: got %b expected 1", sb.busy_a_o); end
    set_btn(0, 0, 0, 0);
    step();
    n_vec++; if (sb.score_a_o !== 7'd1) begin n_err++; $display("FAIL rst_held_edge_score: got %0d expected 1", sb.score_a_o); end
    repeat (HO + 1) step();
  endtask

  task automatic test_single_up();
    do_reset();
    set_btn(1, 0, 0, 0);
    step();
    n_vec++; if (sb.score_a_o !== 7'd0 || sb.busy_a_o !== 1'b1) begin n_err++; $display("FAIL up_pend: got score %0d busy %b expected 0 1", sb.score_a_o, sb.busy_a_o); end
    set_btn(0, 0, 0, 0);
    step();
    n_vec++; if (sb.score_a_o !== 7'd1) begin n_err++; $display("FAIL up_score: got %0d expected 1", sb.score_a_o); end
    n_vec++; if (sb.upd_valid_o !== 1'b1 || sb.upd_team_o !== 1'b0) begin n_err++; $display("FAIL up_upd: got valid %b team %b expected 1 0", sb.upd_valid_o, sb.upd_team_o); end
    step();
    n_vec++; if (sb.upd_valid_o !== 1'b0) begin n_err++; $display("FAIL up_pulse_len: got %b expected 0", sb.upd_valid_o); end
    repeat (HO) step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_btn(1, 0, 1, 0);
    step();
    set_btn(0, 0, 0, 0);
    step();
    n_vec++; if (sb.score_a_o !== 7'd1 || sb.score_b_o !== 7'd0 || sb.upd_team_o !== 1'b0) begin n_err++; $display("FAIL rr1_first: got a %0d b %0d team %b expected 1 0 0", sb.score_a_o, sb.score_b_o, sb.upd_team_o); end
    step();
    n_vec++; if (sb.score_b_o !== 7'd1 || sb.upd_team_o !== 1'b1 || sb.upd_valid_o !== 1'b1) begin n_err++; $display("FAIL rr1_second: got b %0d team %b valid %b expected 1 1 1", sb.score_b_o, sb.upd_team_o, sb.upd_valid_o); end
    repeat (HO + 2) step();
    set_btn(1, 0, 1, 0);
    step();
    set_btn(0, 0, 0, 0);
    step();
    n_vec++; if (sb.score_b_o !== 7'd2 || sb.score_a_o !== 7'd1 || sb.upd_team_o !== 1'b1) begin n_err++; $display("FAIL rr2_first: got a %0d b %0d team %b expected 1 2 1", sb.score_a_o, sb.score_b_o, sb.upd_team_o); end
    step();
    n_vec++; if (sb.score_a_o !== 7'd2 || sb.upd_team_o !== 1'b0) begin n_err++; $display("FAIL rr2_second: got a %0d team %b expected 2 0", sb.score_a_o, sb.upd_team_o); end
    repeat (HO + 2) step();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < MAXV; k++) pulse(0, 1);
    n_vec++; if (sb.score_a_o !== 7'(MAXV)) begin n_err++; $display("FAIL sat_reach: got %0d expected %0d", sb.score_a_o, MAXV); end
    set_btn(1, 0, 0, 1);
    step();
    set_btn(0, 0, 0, 0);
    step();
    n_vec++; if (sb.score_a_o !== 7'(MAXV) || sb.upd_valid_o !== 1'b0 || sb.busy_a_o !== 1'b1) begin n_err++; $display("FAIL sat_top: got score %0d valid %b busy %b expected %0d 0 1", sb.score_a_o, sb.upd_valid_o, sb.busy_a_o, MAXV); end
    step();
    n_vec++; if (sb.score_b_o !== 7'd0 || sb.upd_valid_o !== 1'b0 || sb.busy_b_o !== 1'b1) begin n_err++; $display("FAIL sat_bottom: got score %0d valid %b busy %b expected 0 0 1", sb.score_b_o, sb.upd_valid_o, sb.busy_b_o); end
    repeat (HO + 2) step();
  endtask

  task automatic test_holdoff();
    logic [8:0] pat;
    pat = 9'b0_1000_1001;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      sb.a_up_i = pat[c];
      step();
      if (c == 5) begin
        n_vec++; if (sb.busy_a_o !== 1'b0) begin n_err++; $display("FAIL hold_release: got busy %b expected 0", sb.busy_a_o); end
      end
      if (c == 6) begin
        n_vec++; if (sb.score_a_o !== 7'd1) begin n_err++; $display("FAIL hold_ignored: got %0d expected 1", sb.score_a_o); end
      end
    end
    n_vec++; if (sb.score_a_o !== 7'd2) begin n_err++; $display("FAIL hold_second: got %0d expected 2", sb.score_a_o); end
    set_btn(0, 0, 0, 0);
    repeat (HO + 1) step();
  endtask

  task automatic test_cancel();
    do_reset();
    set_btn(1, 1, 0, 0);
    step();
    n_vec++; if (sb.busy_a_o !== 1'b0) begin n_err++; $display("FAIL cancel_busy: got %b expected 0", sb.busy_a_o); end
    set_btn(0, 0, 0, 0);
    step();
    n_vec++; if (sb.score_a_o !== 7'd0 || sb.upd_valid_o !== 1'b0 || sb.busy_a_o !== 1'b0) begin n_err++; $display("FAIL cancel_nochange: got score %0d valid %b busy %b expected 0 0 0", sb.score_a_o, sb.upd_valid_o, sb.busy_a_o); end
  endtask

  task automatic test_clear();
    do_reset();
    for (int k = 0; k < 12; k++) pulse(0, 1);
    for (int k = 0; k < 34; k++) pulse(1, 1);
    n_vec++; if (sb.score_a_o !== 7'd12 || sb.score_b_o !== 7'd34) begin n_err++; $display("FAIL clr_setup: got %0d/%0d expected 12/34", sb.score_a_o, sb.score_b_o); end
`ifdef SCOREBOARD_BCD_EN
    n_vec++; if (sb.score_b_bcd_o !== 8'h34 || sb.score_a_bcd_o !== 8'h12) begin n_err++; $display("FAIL clr_bcd: got %h/%h expected 12/34", sb.score_a_bcd_o, sb.score_b_bcd_o); end
`endif
    set_btn(0, 0, 1, 0);
    step();
    n_vec++; if (sb.busy_b_o !== 1'b1) begin n_err++; $display("FAIL clr_pend: got busy_b %b expected 1", sb.busy_b_o); end
    set_btn(0, 0, 0, 0);
    sb.clear_i = 1'b1;
    step();
    sb.clear_i = 1'b0;
    n_vec++; if (sb.score_a_o !== 7'd0 || sb.score_b_o !== 7'd0 || sb.upd_valid_o !== 1'b0 || sb.busy_b_o !== 1'b0) begin n_err++; $display("FAIL clr_apply: got %0d/%0d valid %b busy_b %b expected 0/0 0 0", sb.score_a_o, sb.score_b_o, sb.upd_valid_o, sb.busy_b_o); end
    step();
    n_vec++; if (sb.score_b_o !== 7'd0 || sb.upd_valid_o !== 1'b0 || sb.busy_b_o !== 1'b0) begin n_err++; $display("FAIL clr_dropped: got b %0d valid %b busy_b %b expected 0 0 0", sb.score_b_o, sb.upd_valid_o, sb.busy_b_o); end
  endtask

  task automatic test_random();
    logic [BW-1:0] ea, eb;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) sb.a_up_i   = ~sb.a_up_i;
      if ($urandom_range(3, 0) == 0) sb.a_down_i = ~sb.a_down_i;
      if ($urandom_range(3, 0) == 0) sb.b_up_i   = ~sb.b_up_i;
      if ($urandom_range(3, 0) == 0) sb.b_down_i = ~sb.b_down_i;
      sb.clear_i = ($urandom_range(79, 0) == 0);
      step();
      ea = BW'(m_score[0]);
      eb = BW'(m_score[1]);
      n_vec++; if (sb.score_a_o !== ea) begin n_err++; $display("FAIL rnd_score_a cyc %0d: got %0d expected %0d", c, sb.score_a_o, ea); end
      n_vec++; if (sb.score_b_o !== eb) begin n_err++; $display("FAIL rnd_score_b cyc %0d: got %0d expected %0d", c, sb.score_b_o, eb); end
      n_vec++; if (sb.upd_valid_o !== m_uv) begin n_err++; $display("FAIL rnd_upd_valid cyc %0d: got %b expected %b", c, sb.upd_valid_o, m_uv); end
      n_vec++; if (sb.upd_team_o !== m_ut) begin n_err++; $display("FAIL rnd_upd_team cyc %0d: got %b expected %b", c, sb.upd_team_o, m_ut); end
      n_vec++; if (sb.busy_a_o !== (m_pend[0] || m_cool[0] > 0)) begin n_err++; $display("FAIL rnd_busy_a cyc %0d: got %b expected %b", c, sb.busy_a_o, (m_pend[0] || m_cool[0] > 0)); end
      n_vec++; if (sb.busy_b_o !== (m_pend[1] || m_cool[1] > 0)) begin n_err++; $display("FAIL rnd_busy_b cyc %0d: got %b expected %b", c, sb.busy_b_o, (m_pend[1] || m_cool[1] > 0)); end
`ifdef SCOREBOARD_BCD_EN
      n_vec++; if (sb.score_a_bcd_o !== {4'(m_score[0] / 10), 4'(m_score[0] % 10)}) begin n_err++; $display("FAIL rnd_bcd_a cyc %0d: got %h expected score %0d", c, sb.score_a_bcd_o, m_score[0]); end
`endif
    end
    sb.clear_i = 1'b0;
    set_btn(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    sb.clear_i = 1'b0;
    set_btn(0, 0, 0, 0);
    test_reset();
    test_single_up();
    test_back_to_back();
    test_saturate();
    test_holdoff();
    test_cancel();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
